// File: rtl/jtcontra_main_ctrl.sv
// Main-CPU control block: ROM banking, sound-command FIFO with IRQ,
// watchdog and a sequential shift-add protection multiplier.
module jtcontra_main_ctrl #(
  parameter int unsigned       ROM_AW    = 18,
  parameter int unsigned       BANK_W    = 4,
  parameter logic [ROM_AW-1:0] BANK_BASE = ROM_AW'(18'h1_0000),
  parameter int unsigned       SND_DEPTH = 4,
  parameter int unsigned       MUL_W     = 8,
  parameter int unsigned       WDOG_LEN  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cen,
  input  logic [15:0]       A,
  input  logic              RnW,
  input  logic [7:0]        cpu_dout,
  input  logic              io_cs,
  output logic [7:0]        io_dout,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              bank_en,
  output logic [BANK_W-1:0] bank,
  output logic              snd_irq,
  output logic [7:0]        snd_latch,
  input  logic              snd_rd,
  output logic              wdog_rst
);

  localparam int unsigned PTR_W  = $clog2(SND_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(MUL_W) + 1;
  localparam int unsigned PROD_W = 2 * MUL_W;

  logic       wr;
  logic [4:0] reg_off;
  logic       wr_x, wr_y, wr_bank, wr_push, wr_clr, kick;

  assign wr      = io_cs & ~RnW & cpu_cen;
  assign reg_off = A[4:0];
  assign wr_x    = wr && (reg_off == 5'h00);
  assign wr_y    = wr && (reg_off == 5'h01);
  assign wr_bank = wr && (reg_off == 5'h10);
  assign wr_push = wr && (reg_off == 5'h14);
  assign wr_clr  = wr && (reg_off == 5'h15);
  assign kick    = wr && (reg_off == 5'h1C);

  // Bank register
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_en <= 1'b0;
      bank    <= '0;
    end else if (wr_bank) begin
      bank_en <= cpu_dout[4];
      bank    <= BANK_W'(cpu_dout);
    end
  end

  // Extended banks skip bank bit 0, which selects the low 32 kB pair
  always_comb begin
    rom_addr = ROM_AW'(A);
    if (A[15:14] == 2'b01) begin
      if (bank_en) rom_addr = BANK_BASE + ROM_AW'({bank[BANK_W-1:1], A[13:0]});
      else         rom_addr = ROM_AW'({bank[0], A[13:0]});
    end
  end

  // Sound-command FIFO
  logic [7:0]       mem [SND_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow, full, pop, push_ok;

  assign full    = (level == LVL_W'(SND_DEPTH));
  assign pop     = snd_rd && (level != '0);
  assign push_ok = wr_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      snd_irq   <= 1'b0;
      snd_latch <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (wr_push && full && !pop) overflow <= 1'b1;
      else if (wr_clr)             overflow <= 1'b0;
      snd_irq <= (level != '0);
      if (level != '0) snd_latch <= mem[rd_ptr];
    end
  end

  // Shift-add multiplier: one partial product per clk, MUL_W steps
  logic [MUL_W-1:0]  op_x, mp;
  logic [PROD_W-1:0] mc, acc, acc_step, prod;
  logic [CNT_W-1:0]  mul_cnt;
  logic              busy;

  assign acc_step = acc + (mp[0] ? mc : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_x    <= '0;
      mp      <= '0;
      mc      <= '0;
      acc     <= '0;
      prod    <= '0;
      mul_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      if (wr_x) op_x <= MUL_W'(cpu_dout);
      if (wr_y) begin
        busy    <= 1'b1;
        mc      <= PROD_W'(op_x);
        mp      <= MUL_W'(cpu_dout);
        acc     <= '0;
        mul_cnt <= '0;
      end else if (busy) begin
        acc     <= acc_step;
        mc      <= mc << 1;
        mp      <= mp >> 1;
        mul_cnt <= mul_cnt + CNT_W'(1);
        if (mul_cnt == CNT_W'(MUL_W - 1)) begin
          busy <= 1'b0;
          prod <= acc_step;
        end
      end
    end
  end

  always_comb begin
    io_dout = 8'hFF;
    case (reg_off)
      5'h02:   io_dout = 8'(prod);
      5'h03:   io_dout = 8'(prod >> 8);
      5'h04:   io_dout = {6'b0, overflow, busy};
      5'h05:   io_dout = 8'(level);
      default: io_dout = 8'hFF;
    endcase
  end

  // Watchdog: a kick on the expiry tick suppresses the pulse
  if (WDOG_LEN > 0) begin : g_wdog
    localparam int unsigned WD_W = (WDOG_LEN > 1) ? $clog2(WDOG_LEN) : 1;
    logic [WD_W-1:0] wd_cnt;
    logic [4:0]      pulse_cnt;
    logic            expire;

    assign expire = cpu_cen && !kick && (wd_cnt == WD_W'(WDOG_LEN - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        wd_cnt    <= '0;
        pulse_cnt <= '0;
        wdog_rst  <= 1'b0;
      end else begin
        if (kick || expire) wd_cnt <= '0;
        else if (cpu_cen)   wd_cnt <= wd_cnt + WD_W'(1);
        if (expire)                pulse_cnt <= 5'd16;
        else if (pulse_cnt != '0)  pulse_cnt <= pulse_cnt - 5'd1;
        wdog_rst <= expire || (pulse_cnt > 5'd1);
      end
    end
  end else begin : g_no_wdog
    always_ff @(posedge clk) wdog_rst <= 1'b0;
  end

endmodule

// File: tb/tb_jtcontra_main_ctrl.sv
// Directed bench for jtcontra_main_ctrl: banking, FIFO, multiplier,
// watchdog and mid-operation reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_jtcontra_main_ctrl;

  logic        clk = 1'b0;
  logic        rst, cpu_cen, RnW, io_cs, snd_rd;
  logic [15:0] A;
  logic [7:0]  cpu_dout, io_dout, snd_latch;
  logic [17:0] rom_addr;
  logic        bank_en, snd_irq, wdog_rst;
  logic [3:0]  bank;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  jtcontra_main_ctrl #(.WDOG_LEN(16)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .A(A), .RnW(RnW),
    .cpu_dout(cpu_dout), .io_cs(io_cs), .io_dout(io_dout),
    .rom_addr(rom_addr), .bank_en(bank_en), .bank(bank),
    .snd_irq(snd_irq), .snd_latch(snd_latch), .snd_rd(snd_rd),
    .wdog_rst(wdog_rst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic io_wr(input logic [4:0] off, input logic [7:0] d);
    logic saved_cen;
    saved_cen = cpu_cen;
    A = {11'd0, off}; cpu_dout = d; RnW = 1'b0; io_cs = 1'b1; cpu_cen = 1'b1;
    tick();
    io_cs = 1'b0; RnW = 1'b1; cpu_cen = saved_cen;
  endtask

  task automatic pop();
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [4:0] off, input logic [7:0] exp);
    A = {11'd0, off}; RnW = 1'b1;
    #1;
    check(tag, 32'(io_dout), 32'(exp));
  endtask

  task automatic romchk(input string tag, input logic [15:0] a, input logic [17:0] exp);
    A = a;
    #1;
    check(tag, 32'(rom_addr), 32'(exp));
  endtask

  initial begin
    logic [7:0] exp_q [4];
    int hi_cnt;
    logic seen;

    rst = 1'b1; cpu_cen = 1'b0; RnW = 1'b1; io_cs = 1'b0; snd_rd = 1'b0;
    A = 16'h0000; cpu_dout = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_bank_en", 32'(bank_en), 0);
    check("rst_bank", 32'(bank), 0);
    check("rst_irq", 32'(snd_irq), 0);
    check("rst_latch", 32'(snd_latch), 0);
    check("rst_wdog", 32'(wdog_rst), 0);
    rchk("rst_status", 5'h04, 8'h00);
    rchk("rst_level", 5'h05, 8'h00);
    rchk("rst_prod_lo", 5'h02, 8'h00);
    rchk("rst_prod_hi", 5'h03, 8'h00);
    rchk("unmapped_rd", 5'h07, 8'hFF);

    // ROM banking
    io_wr(5'h10, 8'h13);
    check("bank_en_set", 32'(bank_en), 1);
    check("bank_val", 32'(bank), 3);
    romchk("rom_ext", 16'h4123, 18'h1_4123);
    romchk("rom_low", 16'h0123, 18'h0_0123);
    io_wr(5'h10, 8'h01);
    romchk("rom_hi", 16'h8000, 18'h0_8000);
    romchk("rom_nobank1", 16'h4123, 18'h0_4123);
    io_wr(5'h10, 8'h02);
    romchk("rom_nobank0", 16'h4123, 18'h0_0123);
    io_wr(5'h10, 8'h1F);
    romchk("rom_ext_max", 16'h6ABC, 18'h2_EABC);
    io_wr(5'h08, 8'h00);
    check("ignored_wr", 32'(bank), 32'hF);

    // FIFO fill with overflow
    io_wr(5'h14, 8'hA1); io_wr(5'h14, 8'hA2); io_wr(5'h14, 8'hA3);
    io_wr(5'h14, 8'hA4); io_wr(5'h14, 8'hA5);
    rchk("ovf_status", 5'h04, 8'h02);
    rchk("full_level", 5'h05, 8'h04);
    check("full_irq", 32'(snd_irq), 1);
    check("head_A1", 32'(snd_latch), 32'hA1);
    exp_q[0] = 8'hA2; exp_q[1] = 8'hA3; exp_q[2] = 8'hA4;
    for (int i = 0; i < 3; i++) begin
      pop(); tick();
      check("drain_latch", 32'(snd_latch), 32'(exp_q[i]));
    end
    pop();
    check("irq_before_fall", 32'(snd_irq), 1);
    tick();
    check("irq_fall", 32'(snd_irq), 0);
    check("latch_hold", 32'(snd_latch), 32'hA4);
    rchk("empty_level", 5'h05, 8'h00);
    pop();
    rchk("empty_pop_level", 5'h05, 8'h00);
    check("empty_pop_latch", 32'(snd_latch), 32'hA4);
    rchk("ovf_sticky", 5'h04, 8'h02);
    io_wr(5'h15, 8'h00);
    rchk("ovf_clear", 5'h04, 8'h00);

    // Full FIFO, push and pop together
    io_wr(5'h14, 8'hB1); io_wr(5'h14, 8'hB2); io_wr(5'h14, 8'hB3); io_wr(5'h14, 8'hB4);
    snd_rd = 1'b1; io_wr(5'h14, 8'hB5); snd_rd = 1'b0;
    rchk("pp_level", 5'h05, 8'h04);
    rchk("pp_no_ovf", 5'h04, 8'h00);
    tick();
    check("pp_head", 32'(snd_latch), 32'hB2);
    exp_q[0] = 8'hB3; exp_q[1] = 8'hB4; exp_q[2] = 8'hB5;
    for (int i = 0; i < 3; i++) begin
      pop(); tick();
      check("pp_drain", 32'(snd_latch), 32'(exp_q[i]));
    end
    pop();
    rchk("pp_empty", 5'h05, 8'h00);

    // Push and pop together when empty
    snd_rd = 1'b1; io_wr(5'h14, 8'hC1); snd_rd = 1'b0;
    rchk("ep_level", 5'h05, 8'h01);
    tick();
    check("ep_latch", 32'(snd_latch), 32'hC1);
    pop();

    // Multiplier 0xFF * 0xFF
    io_wr(5'h00, 8'hFF);
    io_wr(5'h01, 8'hFF);
    rchk("mulA_busy0", 5'h04, 8'h01);
    rchk("mulA_old", 5'h02, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      tick();
      rchk("mulA_busy", 5'h04, 8'h01);
    end
    tick();
    rchk("mulA_done", 5'h04, 8'h00);
    rchk("mulA_lo", 5'h02, 8'h01);
    rchk("mulA_hi", 5'h03, 8'hFE);

    // Restart while busy: Y=3 then Y=2 three cycles later
    io_wr(5'h01, 8'h03);
    tick(); tick();
    io_wr(5'h01, 8'h02);
    for (int i = 1; i <= 7; i++) begin
      tick();
      rchk("mulB_busy", 5'h04, 8'h01);
      rchk("mulB_old_hi", 5'h03, 8'hFE);
    end
    tick();
    rchk("mulB_done", 5'h04, 8'h00);
    rchk("mulB_lo", 5'h02, 8'hFE);
    rchk("mulB_hi", 5'h03, 8'h01);

    // X written mid-run does not disturb the running multiply
    io_wr(5'h00, 8'h12);
    io_wr(5'h01, 8'h34);
    io_wr(5'h00, 8'h99);
    for (int i = 1; i <= 6; i++) tick();
    rchk("mulC_busy", 5'h04, 8'h01);
    tick();
    rchk("mulC_done", 5'h04, 8'h00);
    rchk("mulC_lo", 5'h02, 8'hA8);
    rchk("mulC_hi", 5'h03, 8'h03);
    io_wr(5'h01, 8'h02);
    for (int i = 1; i <= 8; i++) tick();
    rchk("mulD_lo", 5'h02, 8'h32);
    rchk("mulD_hi", 5'h03, 8'h01);

    // Watchdog: quiesce, then run without kicks
    io_wr(5'h1C, 8'h00);
    repeat (20) tick();
    io_wr(5'h1C, 8'h00);
    check("wd_idle", 32'(wdog_rst), 0);
    cpu_cen = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (wdog_rst) seen = 1'b1;
    end
    check("wd_early", 32'(seen), 0);
    tick();
    check("wd_fire", 32'(wdog_rst), 1);
    cpu_cen = 1'b0;
    hi_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (wdog_rst) hi_cnt++;
    end
    check("wd_pulse_len", 32'(hi_cnt), 15);
    tick();
    check("wd_pulse_end", 32'(wdog_rst), 0);

    // Kicks every 10 cpu_cen
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      cpu_cen = 1'b1;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (wdog_rst) seen = 1'b1;
      end
      io_wr(5'h1C, 8'h00);
      if (wdog_rst) seen = 1'b1;
    end
    cpu_cen = 1'b0;
    check("wd_kicked", 32'(seen), 0);

    // Kick on the expiry cycle
    io_wr(5'h1C, 8'h00);
    cpu_cen = 1'b1;
    for (int i = 1; i <= 15; i++) tick();
    io_wr(5'h1C, 8'h00);
    cpu_cen = 1'b0;
    seen = wdog_rst;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wdog_rst) seen = 1'b1;
    end
    check("wd_kick_wins", 32'(seen), 0);

    // Reset mid-operation
    io_wr(5'h14, 8'hD1);
    io_wr(5'h14, 8'hD2);
    io_wr(5'h00, 8'h05);
    io_wr(5'h01, 8'h07);
    tick();
    rchk("pre_rst_level", 5'h05, 8'h02);
    rchk("pre_rst_busy", 5'h04, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rchk("mid_rst_status", 5'h04, 8'h00);
    rchk("mid_rst_lo", 5'h02, 8'h00);
    rchk("mid_rst_hi", 5'h03, 8'h00);
    rchk("mid_rst_level", 5'h05, 8'h00);
    check("mid_rst_irq", 32'(snd_irq), 0);
    check("mid_rst_latch", 32'(snd_latch), 0);
    check("mid_rst_bank_en", 32'(bank_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
